multi_channel_cycle_timer: RTL and testbench
============================================

Name: multi_channel_cycle_timer

Overview:
- N-channel start-to-trip cycle timer; successor to the two-channel trip counter.
- After `start`, each channel captures the elapsed cycle count at its first `trip` rising edge.
- Adds per-run channel enable mask, saturating counters, a global timeout, and a valid/ack result handshake.
- Sits between sensor trip inputs and the host register/readout logic.

Parameters:
NUM_CH, 4, number of trip channels (1..16)
CNT_W, 32, width of elapsed and captured counts
TIMEOUT_CYC, 1000000, elapsed count at which a run is forced to end; 0 disables timeout

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-low reset
start  in  1  begins (or restarts) a run when sampled high
ch_en  in  NUM_CH  channel enable mask, sampled only on the start edge
trip  in  NUM_CH  per-channel trip inputs, level; rising edge is the event
result_ack  in  1  host accepts result; effective only while result_valid=1
counts  out  NUM_CH*CNT_W  captured counts, channel i at bits [i*CNT_W +: CNT_W]
ch_done  out  NUM_CH  channel i captured in the current/last run
busy  out  1  high in RUN
result_valid  out  1  high in DONE
timed_out  out  1  last run ended by timeout
all_done  out  1  every enabled channel captured in the last run

Behaviour:
- Reset (RST=0 at an edge): state IDLE; all outputs 0; elapsed=0; en_mask=0; trip_q=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- Edge detection:
  - trip_q <= trip every cycle, in all states.
  - Event_i = trip[i] & ~trip_q[i] & en_mask[i] & ~ch_done[i].
  - A trip already high when the run starts is not an event until it falls and rises again.
- start sampled high, any state (start has priority over result_ack and over trips):
  - state <= RUN; elapsed <= 1; en_mask <= ch_en.
  - counts, ch_done, timed_out, all_done cleared to 0; result_valid <= 0.
- RUN, each edge:
  - Capture: for each Event_i, counts[i] <= elapsed and ch_done[i] <= 1.
  - So a trip first sampled high k edges after the start edge yields count k (minimum 1).
  - elapsed <= elapsed+1, saturating at 2^CNT_W-1; captured values saturate likewise.
- RUN exit, evaluated on the same edge's captures:
  - If every en_mask bit is done after this edge's captures: state <= DONE, all_done <= 1, timed_out <= 0.
  - Else if TIMEOUT_CYC!=0 and elapsed==TIMEOUT_CYC: state <= DONE, timed_out <= 1, all_done <= 0.
  - Trips sampled on the timeout edge are still captured; if that completes the set, the run reports all_done=1, timed_out=0.
  - Untripped channels keep counts=0 and ch_done=0.
  - en_mask==0 at start: exits to DONE on the first RUN edge with all_done=1.
- TIMEOUT_CYC > 2^CNT_W-1: the timeout compare uses a separate CNT_W+1-bit-safe compare.
  - Elapsed keeps counting internally; captured values saturate.
  - Implement elapsed as max(CNT_W, clog2(TIMEOUT_CYC+1)) bits.
- DONE:
  - result_valid=1.
  - counts, ch_done, timed_out, all_done held stable.
  - result_ack=1 and start=0 → IDLE; result_valid drops on that edge.
  - Results stay readable in IDLE until the next start.
- busy = (state==RUN). Latency: last trip sampled at edge T → result_valid high after edge T.
- Reset mid-run: immediate return to IDLE; no result is produced.

Decomposition:
- Package cycle_timer_pkg:
  - timer_state_t enum {IDLE, RUN, DONE}.
  - Function sat_inc(value, width).
  - Localparam for the elapsed width computation.
- One sub-module, cycle_timer_channel (instantiated NUM_CH times via generate):
  - trip_q register, event detect, per-channel capture register and done flag.
  - Inputs: clear, en, elapsed.
- The top holds the FSM, elapsed counter, timeout compare and handshake.

Test Plan:
1. NUM_CH=4, ch_en=4'hF; start at edge 0; trips rise at edges 3, 7, 7, 12 → counts {12,7,7,3}, done at edge 12, result_valid after edge 12, all_done=1, timed_out=0.
2. TIMEOUT_CYC=20, ch_en=4'h3; ch0 trips at 5, ch1 never → DONE after edge 20; counts[0]=5, counts[1]=0, ch_done=2'b01, timed_out=1; ch2/ch3 trips ignored.
3. CNT_W=8, TIMEOUT_CYC=0; trip at edge 300 → counts=255, all_done=1.
4. trip[0] held high before start and through edge 4, falls at 5, rises at 9 → counts[0]=9; second rise at 15 not captured.
5. start and result_ack asserted together in DONE → new run, result_valid=0, counts cleared; busy=1.
6. RST low at edge 6 mid-run, high again → state IDLE, all outputs 0, subsequent start runs normally with count from 1.

Source files
------------

// File: rtl/cycle_timer_pkg.sv
// Shared types and helpers for the multi-channel cycle timer.
package cycle_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

   // Widest counter the helpers below handle.
   localparam int SAT_MAX_W = 64;

   // Elapsed counter width: wide enough for both the captured counts and the
   // timeout value, so the timeout is reachable even when counts saturate.
   function automatic int elapsed_width(input int cnt_w, input longint unsigned timeout_cyc);
      int tw;
      tw = $clog2(timeout_cyc + 64'd1);
      return (tw > cnt_w) ? tw : cnt_w;
   endfunction

   // Increment that sticks at the all-ones value of the given width.
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
      logic [63:0] lim;
      lim = (width >= SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
      return (value >= lim) ? lim : value + 64'd1;
   endfunction

endpackage

// File: rtl/multi_channel_cycle_timer_if.sv
// Host/sensor-side bundle of the cycle timer: run control, trips and results.
interface multi_channel_cycle_timer_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
);
   logic                    start;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH-1:0]       trip;
   logic                    result_ack;
   logic [NUM_CH*CNT_W-1:0] counts;
   logic [NUM_CH-1:0]       ch_done;
   logic                    busy;
   logic                    result_valid;
   logic                    timed_out;
   logic                    all_done;

   modport master (
      output start, ch_en, trip, result_ack,
      input  counts, ch_done, busy, result_valid, timed_out, all_done
   );

   modport slave (
      input  start, ch_en, trip, result_ack,
      output counts, ch_done, busy, result_valid, timed_out, all_done
   );
endinterface

// File: rtl/cycle_timer_channel.sv
// One trip channel: rising-edge detect, first-event capture and done flag.
module cycle_timer_channel #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clear,
   input  logic             en,
   input  logic             trip,
   input  logic [CNT_W-1:0] elapsed,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             done_nxt
);
   logic trip_q;
   logic event_hit;

   // Only the first enabled rising edge of a run is captured.
   assign event_hit = trip & ~trip_q & en & ~done;
   assign done_nxt  = done | event_hit;

   // Trip history runs in every state, so a level already high at start is not an edge.
   always_ff @(posedge CLK) begin
      if (!RST) trip_q <= 1'b0;
      else      trip_q <= trip;
   end

   // Capture register: cleared by start, loaded once on the first event.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         count <= '0;
         done  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         done  <= 1'b0;
      end else if (event_hit) begin
         count <= elapsed;
         done  <= 1'b1;
      end
   end
endmodule

// File: rtl/multi_channel_cycle_timer.sv
// N-channel start-to-trip cycle timer: run FSM, elapsed counter, timeout and result handshake.
module multi_channel_cycle_timer
   import cycle_timer_pkg::*;
#(
   parameter int              NUM_CH      = 4,
   parameter int              CNT_W       = 32,
   parameter longint unsigned TIMEOUT_CYC = 1000000
) (
   input logic CLK,
   input logic RST,
   multi_channel_cycle_timer_if.slave bus
);
   localparam int          EW      = elapsed_width(CNT_W, TIMEOUT_CYC);
   localparam logic [63:0] CAP_MAX = (CNT_W >= SAT_MAX_W) ? '1 : ((64'd1 << CNT_W) - 64'd1);
   localparam logic [63:0] TO_VAL  = 64'(TIMEOUT_CYC);

   timer_state_t                  state_q, state_d;
   logic [EW-1:0]                 elapsed;
   logic [NUM_CH-1:0]             en_mask;
   logic [NUM_CH-1:0]             done, done_nxt;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]              cap_val;
   logic                          run, set_all, set_to;
   logic                          busy_q, rv_q, to_q, ad_q;

   assign run     = (state_q == RUN);
   // Elapsed may be wider than the counts; captured values clamp at the count maximum.
   assign cap_val = (64'(elapsed) > CAP_MAX) ? CAP_MAX[CNT_W-1:0] : elapsed[CNT_W-1:0];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      cycle_timer_channel #(.CNT_W(CNT_W)) u_ch (
         .CLK      (CLK),
         .RST      (RST),
         .clear    (bus.start),
         .en       (run & en_mask[i]),
         .trip     (bus.trip[i]),
         .elapsed  (cap_val),
         .count    (cnt[i]),
         .done     (done[i]),
         .done_nxt (done_nxt[i])
      );
   end

   // Next state: start wins over everything; completion is judged on this edge's captures.
   always_comb begin
      state_d = state_q;
      set_all = 1'b0;
      set_to  = 1'b0;
      if (bus.start) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (&(done_nxt | ~en_mask)) begin
                  state_d = DONE;
                  set_all = 1'b1;
               end else if ((TIMEOUT_CYC != 0) && (64'(elapsed) == TO_VAL)) begin
                  state_d = DONE;
                  set_to  = 1'b1;
               end
            end
            DONE:    if (bus.result_ack) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // State, elapsed counter, run mask and registered status outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         elapsed <= '0;
         en_mask <= '0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
         to_q    <= 1'b0;
         ad_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN);
         rv_q    <= (state_d == DONE);
         if (bus.start) begin
            elapsed <= EW'(1);
            en_mask <= bus.ch_en;
            to_q    <= 1'b0;
            ad_q    <= 1'b0;
         end else if (run) begin
            elapsed <= EW'(sat_inc(64'(elapsed), EW));
            if (set_all) ad_q <= 1'b1;
            if (set_to)  to_q <= 1'b1;
         end
      end
   end

   assign bus.counts       = cnt;
   assign bus.ch_done      = done;
   assign bus.busy         = busy_q;
   assign bus.result_valid = rv_q;
   assign bus.timed_out    = to_q;
   assign bus.all_done     = ad_q;
endmodule

// File: tb/tb_multi_channel_cycle_timer.sv
// Scoreboard bench for the cycle timer: planned trip waveforms, expected results from a
// first-rising-edge model, monitor compares each result when result_valid rises.
module tb_multi_channel_cycle_timer;
   localparam int              NC = 4;
   localparam int              CW = 8;
   localparam longint unsigned TO = 400;

   typedef struct {
      logic [NC*CW-1:0] counts;
      logic [NC-1:0]    done;
      logic             to;
      logic             ad;
      int               end_k;
      int               start_edge;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   multi_channel_cycle_timer_if #(.NUM_CH(NC), .CNT_W(CW)) tif();

   multi_channel_cycle_timer #(.NUM_CH(NC), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (tif)
   );

   exp_t sbq[$];
   exp_t last_exp;
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   pre_fall[NC];
   int   rise[NC];
   bit   rv_prev = 1'b0;
   bit   pending = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Planned trip level of channel ch before edge k (k=0 is the start edge).
   function automatic logic level(input int ch, input int k);
      if (k < pre_fall[ch]) return 1'b1;
      if (rise[ch] >= 0 && k >= rise[ch] && k < rise[ch] + 3) return 1'b1;
      if (rise[ch] >= 0 && k >= rise[ch] + 6 && k < rise[ch] + 9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [NC-1:0] levels(input int k);
      logic [NC-1:0] v;
      for (int ch = 0; ch < NC; ch++) v[ch] = level(ch, k);
      return v;
   endfunction

   // Expected outcome: first low-to-high step of each enabled channel, run ends when the
   // last enabled one has stepped, or at the timeout edge otherwise.
   function automatic exp_t model(input logic [NC-1:0] en);
      exp_t e;
      int   first[NC];
      int   tend;
      bit   all;
      tend = 1;
      all  = 1'b1;
      e.counts = '0;
      e.done   = '0;
      e.start_edge = 0;
      for (int ch = 0; ch < NC; ch++) begin
         first[ch] = -1;
         if (en[ch]) begin
            for (int k = 1; k <= int'(TO); k++)
               if (level(ch, k) && !level(ch, k - 1)) begin
                  first[ch] = k;
                  break;
               end
            if (first[ch] < 0) all = 1'b0;
            else if (first[ch] > tend) tend = first[ch];
         end
      end
      if (all) begin
         e.end_k = tend; e.ad = 1'b1; e.to = 1'b0;
      end else begin
         e.end_k = int'(TO); e.ad = 1'b0; e.to = 1'b1;
      end
      for (int ch = 0; ch < NC; ch++)
         if (en[ch] && first[ch] >= 1 && first[ch] <= e.end_k) begin
            e.done[ch] = 1'b1;
            e.counts[ch*CW +: CW] = (first[ch] > 255) ? 8'd255 : 8'(first[ch]);
         end
      return e;
   endfunction

   task automatic set_plan(input int r0, input int r1, input int r2, input int r3);
      rise[0] = r0; rise[1] = r1; rise[2] = r2; rise[3] = r3;
      for (int ch = 0; ch < NC; ch++) pre_fall[ch] = 0;
   endtask

   task automatic rand_plan();
      for (int ch = 0; ch < NC; ch++) begin
         pre_fall[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
         rise[ch] = ($urandom_range(0, 7) == 0) ? -1 :
                    int'($urandom_range(pre_fall[ch] + 1, pre_fall[ch] + 40));
      end
   endtask

   // One run: start edge, then the planned trips; abort_at>=0 stops early without a result.
   task automatic start_run(input logic [NC-1:0] en, input bit with_ack, input int abort_at);
      exp_t e;
      int   n;
      e = model(en);
      e.start_edge = cyc + 1;
      tif.start      = 1'b1;
      tif.ch_en      = en;
      tif.result_ack = with_ack;
      tif.trip       = levels(0);
      if (abort_at < 0) sbq.push_back(e);
      @(posedge CLK); #1;
      tif.start      = 1'b0;
      tif.result_ack = 1'b0;
      tif.ch_en      = NC'($urandom);
      chk("start_busy", tif.busy, 1);
      chk("start_rv", tif.result_valid, 0);
      chk("start_counts", tif.counts, 0);
      chk("start_done", {tif.ch_done, tif.timed_out, tif.all_done}, 0);
      n = (abort_at < 0) ? e.end_k + int'($urandom_range(0, 3)) : abort_at;
      for (int k = 1; k <= n; k++) begin
         tif.trip       = levels(k);
         tif.result_ack = (k <= e.end_k) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge CLK); #1;
      end
      tif.result_ack = 1'b0;
      if (abort_at < 0) begin
         last_exp = e;
         pending  = 1'b1;
      end
   endtask

   task automatic do_ack();
      tif.result_ack = 1'b1;
      @(posedge CLK); #1;
      tif.result_ack = 1'b0;
      chk("ack_rv", tif.result_valid, 0);
      chk("ack_busy", tif.busy, 0);
      chk("idle_counts", tif.counts, last_exp.counts);
      chk("idle_flags", {tif.ch_done, tif.timed_out, tif.all_done},
          {last_exp.done, last_exp.to, last_exp.ad});
      pending = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_counts"}, tif.counts, 0);
      chk({nm, "_flags"}, {tif.ch_done, tif.busy, tif.result_valid, tif.timed_out, tif.all_done}, 0);
   endtask

   // Monitor: one comparison set per rising result_valid.
   always @(negedge CLK) begin
      if (tif.result_valid === 1'b1 && !rv_prev) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got a result at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("counts", tif.counts, mon_e.counts);
            chk("ch_done", tif.ch_done, mon_e.done);
            chk("timed_out", tif.timed_out, mon_e.to);
            chk("all_done", tif.all_done, mon_e.ad);
            chk("latency_edge", cyc, mon_e.start_edge + mon_e.end_k);
            chk("done_busy", tif.busy, 0);
         end
      end
      rv_prev = (tif.result_valid === 1'b1);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at time %0t, expected to be finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NC-1:0] en;
      int            mode;
      exp_t          pe;
      tif.start = 1'b0; tif.ch_en = '0; tif.trip = '0; tif.result_ack = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_zero("reset");
      RST = 1'b1;
      @(posedge CLK); #1;

      // Staggered trips, two on the same edge.
      set_plan(3, 7, 7, 12);
      start_run(4'hF, 1'b0, -1);
      do_ack();
      // Timeout with one channel untripped; disabled channels trip but are ignored.
      set_plan(5, -1, 2, 4);
      start_run(4'h3, 1'b0, -1);
      do_ack();
      // Count saturates while elapsed keeps going.
      set_plan(300, -1, -1, -1);
      start_run(4'h1, 1'b0, -1);
      // Trip high before start, re-rise captured, second pulse ignored; start+ack in DONE.
      set_plan(9, -1, -1, -1);
      pre_fall[0] = 5;
      start_run(4'h1, 1'b1, -1);
      do_ack();
      // Empty mask finishes on the first run edge.
      rand_plan();
      start_run(4'h0, 1'b0, -1);
      do_ack();
      // Reset in the middle of a run.
      set_plan(20, 30, 25, 40);
      start_run(4'hF, 1'b0, 5);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk_zero("midrun_reset");
      RST = 1'b1;
      @(posedge CLK); #1;
      chk_zero("after_reset");
      set_plan(3, 7, 7, 12);
      start_run(4'hF, 1'b0, -1);
      do_ack();

      for (int r = 0; r < 25; r++) begin
         rand_plan();
         en   = NC'($urandom);
         mode = int'($urandom_range(0, 5));
         pe   = model(en);
         if (pending && mode < 2) begin
            start_run(en, 1'b1, -1);
         end else begin
            if (pending) do_ack();
            if (mode == 5 && pe.end_k > 1)
               start_run(en, 1'b0, int'($urandom_range(1, pe.end_k - 1)));
            else
               start_run(en, 1'b0, -1);
         end
      end
      if (pending) do_ack();
      repeat (5) @(posedge CLK);
      #1;
      chk("sb_drain", 64'(sbq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
